// File: rtl/spi_cmd_gen.sv
// Button conditioning (sync, debounce, press detect) plus the command FSM that
// issues one valid/ready transmit request per button_1 press.
module spi_cmd_gen #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_DB_CYCLES  = 1_000_000
) (
  input  logic                    clk_100,
  input  logic                    s_rst,
  input  logic                    button_0,
  input  logic                    button_1,
  input  logic                    tx_ready,
  input  logic                    spi_done,
  output logic                    tx_valid,
  output logic [P_DATA_WIDTH-1:0] tx_data,
  output logic [P_DATA_WIDTH-1:0] data_cnt,
  output logic                    cmd_busy,
  output logic                    req_dropped
);

  localparam int unsigned DB_W = $clog2(P_DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(P_DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Bit 0 carries button_0, bit 1 carries button_1.
  logic [1:0]      raw;
  logic [1:0]      sync_q1;
  logic [1:0]      sync_q2;
  logic [1:0]      db_level;
  logic [1:0]      db_prev;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_t                  state;
  state_t                  state_d;
  logic                    tx_valid_d;
  logic                    cmd_busy_d;
  logic                    req_dropped_d;
  logic [P_DATA_WIDTH-1:0] tx_data_d;
  logic [P_DATA_WIDTH-1:0] data_cnt_d;

  assign raw = {button_1, button_0};

  // Synchroniser and debounce: a new level is accepted after it has been stable long enough.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      db_prev <= db_level;
      for (int i = 0; i < 2; i++) begin
        if (sync_q2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync_q2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // One-cycle pulse on a debounced rising edge; releases produce nothing.
  assign press = db_level & ~db_prev;

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    tx_data_d     = tx_data;
    req_dropped_d = req_dropped;
    data_cnt_d    = data_cnt;

    if (press[0]) begin
      data_cnt_d = data_cnt + P_DATA_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        if (press[1]) begin
          tx_data_d = data_cnt;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (tx_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Requests while busy are not queued, only flagged.
    if (press[1] && (state != IDLE)) begin
      req_dropped_d = 1'b1;
    end

    tx_valid_d = (state_d == REQ);
    cmd_busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      data_cnt    <= '0;
      cmd_busy    <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      state       <= state_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      data_cnt    <= data_cnt_d;
      cmd_busy    <= cmd_busy_d;
      req_dropped <= req_dropped_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_gen.sv
// Scoreboard bench for spi_cmd_gen: expected request words are queued at the
// button_1 press and checked when tx_valid rises.
module tb_spi_cmd_gen;

  localparam int unsigned DW  = 8;
  localparam int unsigned DBC = 4;

  logic          clk_100 = 1'b0;
  logic          s_rst;
  logic          button_0;
  logic          button_1;
  logic          tx_ready;
  logic          spi_done;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [DW-1:0] data_cnt;
  logic          cmd_busy;
  logic          req_dropped;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_cnt;
  logic [DW-1:0] held_data;
  logic          valid_prev = 1'b0;

  spi_cmd_gen #(.P_DATA_WIDTH(DW), .P_DB_CYCLES(DBC)) dut (
    .clk_100    (clk_100),
    .s_rst      (s_rst),
    .button_0   (button_0),
    .button_1   (button_1),
    .tx_ready   (tx_ready),
    .spi_done   (spi_done),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .data_cnt   (data_cnt),
    .cmd_busy   (cmd_busy),
    .req_dropped(req_dropped)
  );

  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: each new request must match the oldest queued word.
  always @(negedge clk_100) begin
    if (tx_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(tx_valid), 32'd0);
      end else begin
        check("req_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      held_data = tx_data;
    end else if (tx_valid && valid_prev && (tx_data != held_data)) begin
      check("req_data_stable", 32'(tx_data), 32'(held_data));
    end
    valid_prev = tx_valid;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic press0();
    button_0 = 1'b1;
    tick(8);
    button_0 = 1'b0;
    tick(8);
    exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!tx_valid && n < 30) begin
      tick();
      n++;
    end
    if (!tx_valid) check(tag, 32'(tx_valid), 32'd1);
  endtask

  task automatic pulse_done();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
  endtask

  initial begin
    int vcnt;
    s_rst = 1'b1; button_0 = 1'b0; button_1 = 1'b0; tx_ready = 1'b0; spi_done = 1'b0;
    exp_cnt = '0;
    tick(2);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_data_cnt", 32'(data_cnt), 32'd0);
    check("rst_busy", 32'(cmd_busy), 32'd0);
    check("rst_dropped", 32'(req_dropped), 32'd0);
    s_rst = 1'b0;
    tick(2);

    // Short glitch is filtered.
    button_0 = 1'b1; tick(3); button_0 = 1'b0; tick(10);
    check("glitch_cnt", 32'(data_cnt), 32'd0);

    // Latency: no change after edge k+5, increment at edge k+6.
    button_0 = 1'b1;
    tick(6);
    check("lat_before", 32'(data_cnt), 32'd0);
    tick(1);
    check("lat_after", 32'(data_cnt), 32'd1);
    tick(3);
    button_0 = 1'b0;
    tick(10);
    exp_cnt = 8'd1;
    check("single_inc", 32'(data_cnt), 32'(exp_cnt));

    // Transfer with a stalled core.
    press0(); press0();
    check("cnt_3", 32'(data_cnt), 32'(exp_cnt));
    exp_q.push_back(exp_cnt);
    button_1 = 1'b1;
    wait_valid("xfer_valid_timeout");
    vcnt = 0;
    for (int i = 0; i < 20 && tx_valid; i++) begin
      vcnt++;
      if (vcnt == 6) tx_ready = 1'b1;
      tick();
    end
    tx_ready = 1'b0;
    button_1 = 1'b0;
    check("valid_cycles", 32'(vcnt), 32'd6);
    check("xfer_tx_data", 32'(tx_data), 32'h03);
    tick(10);
    check("busy_wait", 32'(cmd_busy), 32'd1);
    check("no_valid_wait", 32'(tx_valid), 32'd0);
    pulse_done();
    check("busy_cleared", 32'(cmd_busy), 32'd0);
    tick(2);

    // Simultaneous presses: the request carries the pre-increment count.
    press0(); press0(); press0(); press0();
    check("cnt_7", 32'(data_cnt), 32'h07);
    tx_ready = 1'b1;
    exp_q.push_back(exp_cnt);
    button_0 = 1'b1; button_1 = 1'b1;
    tick(8);
    button_0 = 1'b0; button_1 = 1'b0;
    tick(8);
    exp_cnt = exp_cnt + 8'd1;
    check("sim_cnt", 32'(data_cnt), 32'h08);
    check("sim_tx_data", 32'(tx_data), 32'h07);
    check("sim_busy", 32'(cmd_busy), 32'd1);
    press0();
    check("wait_cnt", 32'(data_cnt), 32'h09);
    check("wait_tx_data", 32'(tx_data), 32'h07);

    // Press while busy is dropped and flagged.
    button_1 = 1'b1; tick(8); button_1 = 1'b0; tick(8);
    check("drop_flag", 32'(req_dropped), 32'd1);
    check("drop_no_valid", 32'(tx_valid), 32'd0);
    pulse_done();
    tick(5);
    check("drop_sticky", 32'(req_dropped), 32'd1);
    check("drop_idle", 32'(cmd_busy), 32'd0);
    tx_ready = 1'b0;

    // Reset mid-REQ.
    s_rst = 1'b1; tick(1); s_rst = 1'b0; tick(1);
    exp_cnt = '0;
    check("rst2_dropped", 32'(req_dropped), 32'd0);
    repeat (5) press0();
    check("cnt_5", 32'(data_cnt), 32'h05);
    exp_q.push_back(exp_cnt);
    button_1 = 1'b1;
    wait_valid("rstreq_valid_timeout");
    s_rst = 1'b1; tick(1);
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_cnt", 32'(data_cnt), 32'd0);
    check("midrst_busy", 32'(cmd_busy), 32'd0);
    check("midrst_dropped", 32'(req_dropped), 32'd0);
    tick(1);
    s_rst = 1'b0; button_1 = 1'b0;
    tick(12);
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    exp_cnt = '0;

    // Wrap.
    repeat (255) press0();
    check("cnt_ff", 32'(data_cnt), 32'hFF);
    press0();
    check("cnt_wrap", 32'(data_cnt), 32'(exp_cnt));
    check("cnt_wrap0", 32'(data_cnt), 32'h00);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_gen.md
# spi_cmd_gen

Upstream command front-end for the SPI transmit core. Conditions the two raw push-button inputs (synchronise, debounce, rising-edge detect), maintains the data counter stepped by `button_0`, and turns each `button_1` press into one transmit request on a valid/ready handshake to the SPI core. It then holds off further requests until the core reports completion.

## Interface
Parameters:
- `P_DATA_WIDTH`, default 8: width of the data counter and of `tx_data`.
- `P_DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new button level. Legal range is 1 or more; benches use 4.

Ports:
- `clk_100`  in  1  system clock. One clock; all state is in this domain.
- `s_rst`  in  1  reset, synchronous and active-high.
- `button_0`  in  1  raw asynchronous button; each press increments the data counter.
- `button_1`  in  1  raw asynchronous button; each press requests one transfer.
- `tx_ready`  in  1  SPI core can accept a request.
- `spi_done`  in  1  one-cycle pulse from the SPI core when the current transfer has finished (CS deasserted).
- `tx_valid`  out  1  transfer request pending.
- `tx_data`  out  P_DATA_WIDTH  word to transmit; stable while `tx_valid`=1.
- `data_cnt`  out  P_DATA_WIDTH  current counter value.
- `cmd_busy`  out  1  high whenever the FSM is not in IDLE.
- `req_dropped`  out  1  sticky flag: a `button_1` press arrived while busy.

## Operation
Button path, identical and independent per button:
- Two-flop synchroniser, `sync_q1` then `sync_q2`.
- Debounce counter, width `$clog2(P_DB_CYCLES+1)`. On each edge:
  - if `sync_q2` equals `db_level`, the counter clears;
  - otherwise, if the counter equals `P_DB_CYCLES-1`, `db_level` takes `sync_q2` and the counter clears;
  - otherwise the counter increments.
- Edge detect: `db_prev` registers `db_level`. The press pulse is `db_level & ~db_prev` and lasts exactly one cycle.
- Releases go through the same debounce but produce no pulse.

Counter:
- A `button_0` pulse sets `data_cnt` to `data_cnt + 1`, modulo 2^P_DATA_WIDTH. 0xFF wraps to 0x00 with no flag.

FSM states are IDLE, REQ and WAIT_DONE.
- IDLE: on a `button_1` pulse, latch `tx_data` from `data_cnt` (the pre-increment value, even if a `button_0` pulse is in the same cycle) and go to REQ.
- REQ: `tx_valid`=1. When `tx_ready`=1 on an edge, the handshake completes and the FSM goes to WAIT_DONE. `tx_data` must not change while in REQ.
- WAIT_DONE: `tx_valid`=0. When `spi_done`=1, return to IDLE.
- `spi_done` outside WAIT_DONE is ignored.
- A `button_1` pulse in REQ or WAIT_DONE is discarded and sets `req_dropped`. It is not queued.
- `button_0` pulses are accepted in every state. They change `data_cnt` but never the latched `tx_data`.

## Timing
Reset values, after any edge with `s_rst`=1:
- `tx_valid`=0, `tx_data`=0, `data_cnt`=0, `cmd_busy`=0, `req_dropped`=0.
- FSM in IDLE.
- Synchronisers, `db_level`, `db_prev` and debounce counters all 0.

Reset mid-transfer:
- An assertion in REQ or WAIT_DONE aborts immediately, with no handshake completion.
- A button held across reset deasserting is accepted as a new press after debounce, because `db_level` restarts at 0.

Latency:
- Raw level first sampled at edge k is visible on `sync_q2` after edge k+1.
- `db_level` toggles at edge k+1+P_DB_CYCLES.
- `data_cnt` updates, or the FSM enters REQ, at edge k+2+P_DB_CYCLES.
- Total: P_DB_CYCLES+3 edges from the first sampling edge to the visible effect.

Filtering:
- A pulse or glitch held for fewer than P_DB_CYCLES cycles on `sync_q2` produces no press.

Handshake:
- `tx_valid` rises in the cycle after the accepting edge. The minimum REQ duration is 1 cycle, when `tx_ready` is already high.
- `cmd_busy` equals (state != IDLE), registered with the state.
- A new request is accepted at the earliest 1 cycle after `spi_done` returns the FSM to IDLE.

## Test plan
Bench settings: P_DB_CYCLES=4, P_DATA_WIDTH=8.
- **Reset:** assert `s_rst` for 2 cycles mid-REQ, with `data_cnt`=0x05 → all outputs 0 at the next edge; FSM is IDLE.
- **Debounce:** `button_0` high for 3 cycles, then low → `data_cnt` stays 0x00. High for 10 cycles → `data_cnt`=0x01, exactly 7 edges after the first sampling edge, and increments only once.
- **Wrap:** 256 clean `button_0` presses → `data_cnt` returns to 0x00. The 255th press leaves 0xFF.
- **Transfer:** with `data_cnt`=0x03, press `button_1` while holding `tx_ready`=0 for 5 cycles, then 1 → `tx_valid` high for 6 cycles with `tx_data`=0x03. `cmd_busy` stays high until 1 cycle after a `spi_done` pulse.
- **Simultaneous:** `button_0` and `button_1` pulses on the same edge from `data_cnt`=0x07 → `tx_data`=0x07 and `data_cnt`=0x08. A further `button_0` press during WAIT_DONE → `data_cnt`=0x09 while `tx_data` stays 0x07.
- **Dropped:** a `button_1` press during WAIT_DONE → no second `tx_valid` and `req_dropped`=1. The flag stays 1 after `spi_done` and clears only on `s_rst`.
